dff_response_checker: RTL
=========================

# dff_response_checker

Synthesizable response checker for the flip-flop stimulus interface: while a stimulus source drives D/clock into a DFF under test, this block receives the DUT's Q/QN, predicts the expected Q from a delayed copy of D, and counts mismatches. It is the receiving/checking end of the DFF stimulus path, so gate-level storage elements can be self-checked in simulation and on hardware without a $monitor log. One run covers a fixed number of checks and ends in a PASS/FAIL verdict.

## Interface
- LATENCY, 1, clock edges from D being sampled by the DUT to the resulting Q being checkable; legal 1..8
- NUM_CHECKS, 16, comparisons per run; legal 1..2^CNT_W-1
- CNT_W, 8, width of counters and FIRST_ERR
- CLK  in  1  single clock; all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  run request; sampled only in IDLE or DONE
- D  in  1  stimulus value presented to the DUT this cycle
- Q  in  1  DUT true output
- QN  in  1  DUT complementary output
- BUSY  out  1  high in FILL and CHECK
- DONE  out  1  high in DONE until the next accepted START
- PASS  out  1  DONE && ERR_CNT==0 && !COMP_ERR
- CHK_CNT  out  CNT_W  comparisons performed this run
- ERR_CNT  out  CNT_W  failing comparisons this run
- COMP_ERR  out  1  sticky: some check saw QN != ~Q
- FIRST_ERR  out  CNT_W  CHK_CNT value at the first failing check; all-ones if none

## Operation
- One clock, CLK; reset is asynchronous and active-low on RST_N.
- Reset (RST_N=0, any time, including mid-run): state IDLE; BUSY=0, DONE=0, PASS=0, CHK_CNT=0, ERR_CNT=0, COMP_ERR=0, FIRST_ERR=all-ones; delay pipe data and valid bits cleared.
- States: IDLE, FILL, CHECK, DONE.
- IDLE/DONE, START=1: clear counters, COMP_ERR, FIRST_ERR (all-ones), pipe valid bits; load pipe[0]<=D, valid[0]<=1; go FILL if LATENCY>1, else CHECK.
- IDLE/DONE, START=0: hold; all outputs hold.
- FILL/CHECK: every edge pipe shifts (pipe[i]<=pipe[i-1], pipe[0]<=D, valid likewise with valid[0]<=1); START ignored.
- FILL -> CHECK on the edge that sets valid[LATENCY-1].
- CHECK, each edge: expected = pipe[LATENCY-1]; check fails if Q != expected or QN != ~Q. CHK_CNT += 1; on failure ERR_CNT += 1, COMP_ERR set if QN != ~Q, and FIRST_ERR <= old CHK_CNT if FIRST_ERR is all-ones.
- CHECK -> DONE on the edge where CHK_CNT goes to NUM_CHECKS; no further comparisons.
- ERR_CNT <= CHK_CNT <= NUM_CHECKS, so counters never wrap; no saturation logic.
- Unknown Q/QN (X) counts as a failure in simulation.

## Timing
- D sampled at edge k is compared against Q sampled at edge k+LATENCY (LATENCY=1: edge-triggered DFF updates at edge k, Q stable before k+1).
- START edge = edge 0; first comparison at edge LATENCY; last at edge LATENCY+NUM_CHECKS-1; DONE=1 immediately after that edge.
- FILL occupies edges 1..LATENCY-1 (absent for LATENCY=1).
- All outputs registered; PASS valid in the same cycle DONE rises.
- START held high through DONE restarts on the first edge in DONE (back-to-back runs, one DONE cycle between).

## Test plan
- LATENCY=1, NUM_CHECKS=4, ideal DFF model, D=1,0,1,1,0 from START edge -> DONE after edge 4, CHK_CNT=4, ERR_CNT=0, FIRST_ERR=all-ones, PASS=1.
- Same, DUT Q stuck at 0 (QN=~Q), D=1,0,1,1 -> ERR_CNT=3, FIRST_ERR=0, COMP_ERR=0, PASS=0.
- Ideal DFF but QN tied to Q -> every check fails: ERR_CNT=4, COMP_ERR=1, FIRST_ERR=0.
- LATENCY=3 with 3-stage shift-register DUT, NUM_CHECKS=5 -> BUSY edges 1..7, first check edge 3, DONE after edge 7, PASS=1; same DUT with LATENCY=2 -> ERR_CNT>0.
- RST_N low mid-CHECK (async, between edges) -> all outputs immediately at reset values; next START begins clean run and passes.
- START pulsed during CHECK -> ignored, run completes normally; START in DONE -> counters cleared, DONE=0, BUSY=1 next cycle.

Source files
------------

// File: rtl/dff_response_checker_if.sv
// Handshake bundle between a DFF stimulus/DUT harness and its checker.
// Master drives START/D/Q/QN; slave returns status and counters.
interface dff_response_checker_if #(
  parameter int CNT_W = 8
);
  logic             START;
  logic             D;
  logic             Q;
  logic             QN;
  logic             BUSY;
  logic             DONE;
  logic             PASS;
  logic             COMP_ERR;
  logic [CNT_W-1:0] CHK_CNT;
  logic [CNT_W-1:0] ERR_CNT;
  logic [CNT_W-1:0] FIRST_ERR;

  modport master (
    output START, D, Q, QN,
    input  BUSY, DONE, PASS, COMP_ERR,
    input  CHK_CNT, ERR_CNT, FIRST_ERR
  );

  modport slave (
    input  START, D, Q, QN,
    output BUSY, DONE, PASS, COMP_ERR,
    output CHK_CNT, ERR_CNT, FIRST_ERR
  );
endinterface

// File: rtl/dff_response_checker.sv
// Response checker for a DFF under test: delays D by LATENCY edges,
// compares against Q/QN, counts mismatches and gives a PASS verdict.
// Ports: CLK, RST_N (async low), bus (slave: START/D/Q/QN in;
//   BUSY/DONE/PASS/COMP_ERR/CHK_CNT/ERR_CNT/FIRST_ERR out).
module dff_response_checker #(
  parameter int LATENCY    = 1,
  parameter int NUM_CHECKS = 16,
  parameter int CNT_W      = 8
) (
  input logic                  CLK,
  input logic                  RST_N,
  dff_response_checker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] ALL1 = '1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHECKS);

  state_t             state_q;
  logic [LATENCY-1:0] pipe_q;
  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] pipe_d;
  logic [LATENCY-1:0] vld_d;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic               comp_q;
  logic [CNT_W-1:0]   chk_q;
  logic [CNT_W-1:0]   err_q;
  logic [CNT_W-1:0]   first_q;

  logic               exp_bit;
  logic               q_ok;
  logic               qn_ok;
  logic               fail;
  logic               cfail;
  logic [CNT_W-1:0]   chk_d;
  logic [CNT_W-1:0]   err_d;
  logic               comp_d;

  assign pipe_d  = LATENCY'({pipe_q, bus.D});
  assign vld_d   = LATENCY'({vld_q, 1'b1});
  assign exp_bit = pipe_q[LATENCY-1];
  assign q_ok    = bus.Q ~^ exp_bit;
  assign qn_ok   = bus.QN ^ bus.Q;

  // Failure defaults to 1 so an X on Q/QN lands on the failing side.
  always_comb begin
    fail  = 1'b1;
    cfail = 1'b1;
    if (q_ok & qn_ok) fail = 1'b0;
    if (qn_ok) cfail = 1'b0;
  end

  assign chk_d  = chk_q + 1'b1;
  assign err_d  = err_q + CNT_W'(fail);
  assign comp_d = comp_q | cfail;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      pipe_q  <= '0;
      vld_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      comp_q  <= 1'b0;
      chk_q   <= '0;
      err_q   <= '0;
      first_q <= ALL1;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.START) begin
            pipe_q  <= LATENCY'(bus.D);
            vld_q   <= LATENCY'(1'b1);
            chk_q   <= '0;
            err_q   <= '0;
            comp_q  <= 1'b0;
            first_q <= ALL1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            state_q <= (LATENCY > 1) ? S_FILL : S_CHECK;
          end
        end
        S_FILL: begin
          pipe_q <= pipe_d;
          vld_q  <= vld_d;
          if (vld_d[LATENCY-1]) state_q <= S_CHECK;
        end
        S_CHECK: begin
          pipe_q <= pipe_d;
          vld_q  <= vld_d;
          chk_q  <= chk_d;
          err_q  <= err_d;
          comp_q <= comp_d;
          if (fail && first_q == ALL1) first_q <= chk_q;
          if (chk_d == LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0) && !comp_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.PASS      = pass_q;
  assign bus.COMP_ERR  = comp_q;
  assign bus.CHK_CNT   = chk_q;
  assign bus.ERR_CNT   = err_q;
  assign bus.FIRST_ERR = first_q;

endmodule
